imu_spi_seq: RTL

//  Sequencer that owns the SPI monarch: after power-up it waits, writes three init commands to the

---
 rtl/imu_spi_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/imu_spi_seq.sv
// IMU SPI sequencer: power-up wait, three init writes, then
// INT-driven yaw-rate low/high reads into a 16-bit sample.
module imu_spi_seq #(
  parameter int          WAIT_W    = 16,
  parameter logic [15:0] CMD_INIT0 = 16'h0D02,
  parameter logic [15:0] CMD_INIT1 = 16'h1160,
  parameter logic [15:0] CMD_INIT2 = 16'h1440,
  parameter logic [15:0] CMD_RDL   = 16'hA600,
  parameter logic [15:0] CMD_RDH   = 16'hA700
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] resp,
  output logic        snd,
  output logic [15:0] cmd,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        init_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    WAIT_PWR,
    INIT0,
    INIT1,
    INIT2,
    IDLE,
    RD_L,
    RD_H
  } state_t;

  state_t            state, state_n;
  logic [WAIT_W-1:0] wcnt, wcnt_n;
  logic              snd_n;
  logic [15:0]       cmd_n;
  logic [15:0]       yaw_n;
  logic [7:0]        low, low_n;
  logic              vld_n;
  logic              init_n;
  logic              int_s1, int_s;
  logic              done_q;
  logic              cmpl;
  logic              acc;
  logic              resp_unused;

  assign resp_unused = ^resp[15:8];
  assign cmpl = done & ~done_q;
  // completion only counts in the wait phase, never in the issue cycle
  assign acc  = cmpl & ~snd;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WAIT_PWR;
      wcnt      <= '0;
      snd       <= 1'b0;
      cmd       <= 16'h0000;
      yaw_rt    <= 16'h0000;
      low       <= 8'h00;
      vld       <= 1'b0;
      init_done <= 1'b0;
      int_s1    <= 1'b0;
      int_s     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      wcnt      <= wcnt_n;
      snd       <= snd_n;
      cmd       <= cmd_n;
      yaw_rt    <= yaw_n;
      low       <= low_n;
      vld       <= vld_n;
      init_done <= init_n;
      int_s1    <= INT;
      int_s     <= int_s1;
      done_q    <= done;
    end
  end

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    snd_n   = 1'b0;
    cmd_n   = cmd;
    yaw_n   = yaw_rt;
    low_n   = low;
    vld_n   = 1'b0;
    init_n  = init_done;
    unique case (state)
      WAIT_PWR: begin
        wcnt_n = wcnt + WAIT_W'(1);
        if (&wcnt) begin
          state_n = INIT0;
          snd_n   = 1'b1;
          cmd_n   = CMD_INIT0;
        end
      end
      INIT0: if (acc) begin
        state_n = INIT1;
        snd_n   = 1'b1;
        cmd_n   = CMD_INIT1;
      end
      INIT1: if (acc) begin
        state_n = INIT2;
        snd_n   = 1'b1;
        cmd_n   = CMD_INIT2;
      end
      INIT2: if (acc) begin
        state_n = IDLE;
        init_n  = 1'b1;
      end
      IDLE: if (int_s) begin
        state_n = RD_L;
        snd_n   = 1'b1;
        cmd_n   = CMD_RDL;
      end
      RD_L: if (acc) begin
        low_n   = resp[7:0];
        state_n = RD_H;
        snd_n   = 1'b1;
        cmd_n   = CMD_RDH;
      end
      RD_H: if (acc) begin
        yaw_n   = {resp[7:0], low};
        vld_n   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = WAIT_PWR;
    endcase
  end

endmodule
